instr_prefetch: RTL and testbench
=================================

Name: instr_prefetch

Overview:
- Instruction prefetch stage between the instruction memory and the core fetch path.
- Issues sequential word fetches ahead of the core and buffers the returned instructions with their PCs in an in-order FIFO of DEPTH entries.
- Presents the buffered instructions to the core over a valid/ready handshake.
- A flush (taken jump/branch) redirects fetching and discards buffered and in-flight instructions.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of 2, >=2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch word address
- mem_gnt  in  1  request accepted this cycle when mem_req=1
- mem_rvalid  in  1  in-order read data valid
- mem_rdata  in  32  instruction word
- flush  in  1  redirect request from core
- flush_pc  in  32  redirect target; bits[1:0] ignored (treated as 0)
- instr_valid  out  1  instr/instr_pc valid
- instr  out  32  instruction to core
- instr_pc  out  32  PC of instr
- instr_ready  in  1  core consumes head entry

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, FIFO empty, outstanding=0, state=RUN.
- Counters: count and outstanding are $clog2(DEPTH+1) bits wide.
- Fetch PC:
  - fetch_pc increments by 4 on each grant (mem_req & mem_gnt); wraps mod 2^32.
  - mem_addr = fetch_pc.
- Request rule: mem_req = (state==RUN) & !flush & (count + outstanding < DEPTH). This guarantees every response has a FIFO slot, so no overflow is possible.
- Outstanding count: +1 on grant, -1 on mem_rvalid; both in the same cycle leaves it unchanged. Memory latency is >=1 cycle after grant; responses return in order.
- Response capture: a response in RUN is pushed as {mem_rdata, pc}. pc comes from an internal PC queue (or pc base + offset), matching request order.
- Output: instr_valid = FIFO non-empty; instr/instr_pc = head entry. Pop on instr_valid & instr_ready.
- Push and pop in the same cycle: count unchanged.
- Latency without the optional feature: response to instr_valid is 1 cycle.
- FSM states:
  - RUN: normal operation.
  - DRAIN: discarding stale responses; mem_req=0.
- Flush (highest priority, any state):
  - FIFO cleared; any pop that cycle is irrelevant.
  - fetch_pc <= flush_pc.
  - discard_cnt <= outstanding - mem_rvalid; the response arriving in the flush cycle is discarded.
  - Next state: DRAIN if discard_cnt != 0, else RUN.
- DRAIN:
  - Each mem_rvalid is dropped and decrements discard_cnt.
  - At discard_cnt==1 with mem_rvalid, go to RUN next cycle; requests resume then.
  - A second flush in DRAIN reloads fetch_pc and keeps discard_cnt, which is still decremented by any mem_rvalid that cycle.
- Reset mid-operation: all state returns to reset values next cycle. Responses to pre-reset requests must not arrive; the memory shares rst.
- Full FIFO with instr_ready=0: mem_req stays 0 until a pop; no data is lost.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state==RUN, mem_rvalid=1 and flush=0, the response drives instr/instr_pc/instr_valid combinationally in the same cycle.
  - If instr_ready=1, the word is consumed and not written to the FIFO.
  - If instr_ready=0, it is pushed normally.
  - Latency is 0 cycles.
- Undefined: all responses go through the FIFO; latency is 1 cycle; outputs are purely registered/FIFO-driven.

Decomposition:
- Shared package (rv_core_pkg):
  - XLEN=32
  - INSTR_NOP=32'h0000_0013
  - PC_STEP=4
  - prefetch state enum {PF_RUN, PF_DRAIN}
- One sub-module: pf_fifo, a synchronous FIFO of {pc[31:0], instr[31:0]} with push/pop/clear, count, empty and full outputs.
- The PC queue reuses a second pf_fifo instance or pc-tracking counters.

Test Plan:
- Reset, memory latency 1, instr_ready=1: requests at 0x0, 0x4, 0x8, ...; instr_pc sequence 0x0, 0x4, 0x8 in order; no gaps after fill.
- instr_ready=0 for 10 cycles: exactly DEPTH=4 grants, then mem_req=0. Release ready: 4 pops with pc 0x0–0xC, then fetching resumes at 0x10.
- 2 outstanding requests, flush with flush_pc=0x100: next 2 responses dropped (state DRAIN, mem_req=0), then first request at 0x100; instr_pc 0x100 is the first delivered.
- Flush coincident with mem_rvalid and 1 outstanding: that response is dropped, discard_cnt=0, state stays RUN, request to flush_pc next cycle.
- Random latency 1–5 with random instr_ready and flushes: scoreboard checks in-order PCs, no stale instructions, and count+outstanding never exceeds 4.
- With PREFETCH_BYPASS_EN, empty FIFO, rvalid with rdata=0x00000013 and ready=1: instr_valid=1 in the same cycle and FIFO count stays 0.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// rv_core_pkg: shared core constants and the prefetch FSM state type.
package rv_core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic {PF_RUN, PF_DRAIN} pf_state_e;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: memory fetch port, core redirect and instruction handshake.
interface instr_prefetch_if;
  logic mem_req;
  logic [rv_core_pkg::XLEN-1:0] mem_addr;
  logic mem_gnt;
  logic mem_rvalid;
  logic [rv_core_pkg::XLEN-1:0] mem_rdata;
  logic flush;
  logic [rv_core_pkg::XLEN-1:0] flush_pc;
  logic instr_valid;
  logic [rv_core_pkg::XLEN-1:0] instr;
  logic [rv_core_pkg::XLEN-1:0] instr_pc;
  logic instr_ready;
  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input mem_gnt, mem_rvalid, mem_rdata, flush, flush_pc, instr_ready
  );
  modport slave (
    input mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_gnt, mem_rvalid, mem_rdata, flush, flush_pc, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_fifo.sv
// pf_fifo: synchronous FIFO with push/pop/clear, occupancy count and empty/full flags.
module pf_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [CW-1:0] count,
  output logic empty,
  output logic full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetcher with flush/drain and an in-order buffer.
// Define PREFETCH_BYPASS_EN to forward a response straight to the core when the buffer is empty.
module instr_prefetch
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  instr_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  pf_state_e state, state_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc, tgt;
  logic [CW-1:0] outstanding, discard_cnt, discard_nxt, count;
  logic [2*XLEN-1:0] head;
  logic empty, full, grant, run_rsp, push, pop;
  assign tgt = {bus.flush_pc[XLEN-1:2], 2'b00};
  // Credit check: every in-flight request is guaranteed a buffer slot on return.
  assign bus.mem_req = !rst && state == PF_RUN && !bus.flush && !full &&
                       (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign bus.mem_addr = fetch_pc;
  assign grant = bus.mem_req && bus.mem_gnt;
  assign run_rsp = state == PF_RUN && !bus.flush && bus.mem_rvalid;
  assign pop = bus.instr_ready && !bus.flush;
`ifdef PREFETCH_BYPASS_EN
  logic byp;
  assign byp = run_rsp && empty;
  assign push = run_rsp && !(byp && bus.instr_ready);
  assign bus.instr_valid = !empty || byp;
  assign bus.instr = byp ? bus.mem_rdata : head[XLEN-1:0];
  assign bus.instr_pc = byp ? rsp_pc : head[2*XLEN-1:XLEN];
`else
  assign push = run_rsp;
  assign bus.instr_valid = !empty;
  assign bus.instr = head[XLEN-1:0];
  assign bus.instr_pc = head[2*XLEN-1:XLEN];
`endif
  pf_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(bus.flush),
    .push(push),
    .pop(pop),
    .din({rsp_pc, bus.mem_rdata}),
    .dout(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  always_comb begin
    discard_nxt = (bus.flush && state == PF_RUN) ? outstanding - CW'(bus.mem_rvalid) :
                  (state == PF_DRAIN) ? discard_cnt - CW'(bus.mem_rvalid) : '0;
    state_nxt = (discard_nxt != '0) ? PF_DRAIN : PF_RUN;
  end
  // rsp_pc tracks the PC of the next non-discarded response, so no PC queue is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PF_RUN;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state <= state_nxt;
      discard_cnt <= discard_nxt;
      outstanding <= outstanding + CW'(grant) - CW'(bus.mem_rvalid);
      fetch_pc <= bus.flush ? tgt : grant ? fetch_pc + PC_STEP : fetch_pc;
      rsp_pc <= bus.flush ? tgt : run_rsp ? rsp_pc + PC_STEP : rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed table, corner sequences and random traffic against a queue model.
module tb_instr_prefetch;
  import rv_core_pkg::*;
  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    int due;
    bit stale;
  } req_t;
  typedef struct {
    logic ready;
    logic rv;
    logic [31:0] rv_addr;
    logic req;
    logic [31:0] addr;
    logic v;
    logic vb;
    logic [31:0] pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  req_t mq[$];
  logic [31:0] fq[$];
  logic [31:0] m_pc;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  instr_prefetch_if bus ();
  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return a ^ INSTR_NOP;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_gnt = 0; bus.instr_ready = 0; bus.flush = 0; bus.flush_pc = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    fq.delete();
    m_pc = 32'h0;
  endtask

  // One cycle of memory + core stimulus, checked against the queue model.
  task automatic step(input logic g, input logic r, input logic f, input logic [31:0] fpc, input int lat);
    logic rv, exp_req, exp_valid, st, fresh, byp;
    logic [31:0] exp_pc;
    req_t e;
    @(negedge clk);
    rv = mq.size() > 0 && mq[0].due <= cyc;
    bus.mem_gnt = g; bus.instr_ready = r; bus.flush = f; bus.flush_pc = fpc;
    bus.mem_rvalid = rv;
    bus.mem_rdata = rv ? dfun(mq[0].addr) : 32'h0;
    #1;
    st = 0;
    foreach (mq[i]) if (mq[i].stale) st = 1;
    fresh = rv && !mq[0].stale;
    exp_req = !f && !st && (fq.size() + mq.size() < DEPTH);
    byp = BYP && fq.size() == 0 && fresh && !f;
    exp_valid = fq.size() > 0 || byp;
    chk("mem_req", bus.mem_req, exp_req);
    if (exp_req) chk("mem_addr", bus.mem_addr, m_pc);
    chk("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      exp_pc = fq.size() > 0 ? fq[0] : mq[0].addr;
      chk("instr_pc", bus.instr_pc, exp_pc);
      chk("instr", bus.instr, dfun(exp_pc));
    end
    s_req = bus.mem_req; s_addr = bus.mem_addr; s_valid = bus.instr_valid;
    s_pc = bus.instr_pc; s_instr = bus.instr;
    if (f) begin
      fq.delete();
      if (rv) void'(mq.pop_front());
      foreach (mq[i]) mq[i].stale = 1;
      m_pc = {fpc[31:2], 2'b00};
    end else begin
      if (fq.size() > 0 && r) void'(fq.pop_front());
      if (rv) begin
        e = mq.pop_front();
        if (!e.stale && !(byp && r)) fq.push_back(e.addr);
      end
    end
    if (exp_req && g) begin
      mq.push_back('{addr: m_pc, due: cyc + lat, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    vec_t tbl[14];
    int n;
    logic ev;
    bus.mem_gnt = 0; bus.instr_ready = 0; bus.flush = 0; bus.flush_pc = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    // Latency-1 fill with the core stalled, then release.
    tbl[0]  = '{0, 0, 32'h00, 1, 32'h04 - 4, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h00, 1, 32'h04, 0, 1, 32'h0};
    tbl[2]  = '{0, 1, 32'h04, 1, 32'h08, 1, 1, 32'h0};
    tbl[3]  = '{0, 1, 32'h08, 1, 32'h0C, 1, 1, 32'h0};
    tbl[4]  = '{0, 1, 32'h0C, 0, 32'h10, 1, 1, 32'h0};
    tbl[5]  = '{0, 0, 32'h00, 0, 32'h10, 1, 1, 32'h0};
    tbl[6]  = '{0, 0, 32'h00, 0, 32'h10, 1, 1, 32'h0};
    tbl[7]  = '{0, 0, 32'h00, 0, 32'h10, 1, 1, 32'h0};
    tbl[8]  = '{0, 0, 32'h00, 0, 32'h10, 1, 1, 32'h0};
    tbl[9]  = '{1, 0, 32'h00, 0, 32'h10, 1, 1, 32'h0};
    tbl[10] = '{1, 0, 32'h00, 1, 32'h10, 1, 1, 32'h4};
    tbl[11] = '{1, 1, 32'h10, 1, 32'h14, 1, 1, 32'h8};
    tbl[12] = '{1, 1, 32'h14, 1, 32'h18, 1, 1, 32'hC};
    tbl[13] = '{1, 1, 32'h18, 1, 32'h1C, 1, 1, 32'h10};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.mem_gnt = 1; bus.flush = 0; bus.instr_ready = tbl[i].ready;
      bus.mem_rvalid = tbl[i].rv;
      bus.mem_rdata = dfun(tbl[i].rv_addr);
      #1;
      chk($sformatf("tbl%0d_req", i), bus.mem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].addr);
      ev = BYP ? tbl[i].vb : tbl[i].v;
      chk($sformatf("tbl%0d_valid", i), bus.instr_valid, ev);
      if (ev) begin
        chk($sformatf("tbl%0d_pc", i), bus.instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), bus.instr, dfun(tbl[i].pc));
      end
    end

    // Flush with two requests in flight.
    do_reset();
    step(1, 1, 0, 0, 3);
    step(1, 1, 0, 0, 3);
    step(0, 1, 1, 32'h100, 3);
    n = 0;
    do begin step(1, 1, 0, 0, 3); n++; end while (!s_req && n < 10);
    chk("drain_steps", n, 3);
    chk("redirect_addr", s_addr, 32'h100);
    n = 0;
    do begin step(0, 1, 0, 0, 3); n++; end while (!s_valid && n < 10);
    chk("redirect_valid", s_valid, 1);
    chk("redirect_first_pc", s_pc, 32'h100);

    // Flush coinciding with the only outstanding response.
    do_reset();
    step(1, 1, 0, 0, 1);
    step(0, 1, 1, 32'h203, 1);
    chk("coinc_valid", s_valid, 0);
    step(1, 1, 0, 0, 1);
    chk("coinc_req", s_req, 1);
    chk("coinc_addr", s_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);

`ifdef PREFETCH_BYPASS_EN
    do_reset();
    step(1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("byp_valid", s_valid, 1);
    chk("byp_instr", s_instr, INSTR_NOP);
    step(0, 1, 0, 0, 1);
    chk("byp_not_buffered", s_valid, 0);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < (i < 1500 ? 6 : 3),
           $urandom_range(0, 31) == 0, $urandom, $urandom_range(1, 5));
    do_reset();
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 1) != 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 63) == 0, $urandom, $urandom_range(1, 5));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
